// File: rtl/leaky_relu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaky_relu_seq_ctrl                                                  |
// | Job sequencer: activation SRAM -> leaky ReLU lanes -> output SRAM.   |
// | Optional macro LRELU_SEQ_PERF_EN adds perf_cycles / perf_stalls.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module leaky_relu_seq_ctrl #(
  parameter int RELU_SIZE          = 4,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ALPHA              = 2,
  parameter int ADDR_WIDTH         = 10,
  parameter int LEN_WIDTH          = 11
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [ADDR_WIDTH-1:0]                   src_base,
  input  logic [ADDR_WIDTH-1:0]                   dst_base,
  input  logic [LEN_WIDTH-1:0]                    len,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    rd_en,
  output logic [ADDR_WIDTH-1:0]                   rd_addr,
  input  logic [RELU_SIZE*COMPUTE_DATA_WIDTH-1:0] rd_data,
  output logic                                    wr_en,
  output logic [ADDR_WIDTH-1:0]                   wr_addr,
  output logic [RELU_SIZE*COMPUTE_DATA_WIDTH-1:0] wr_data,
`ifdef LRELU_SEQ_PERF_EN
  output logic [31:0]                             perf_cycles,
  output logic [31:0]                             perf_stalls,
`endif
  input  logic                                    wr_ready
);

  localparam int c_word_w = RELU_SIZE * COMPUTE_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_src, r_dst;
  logic [LEN_WIDTH-1:0]  r_len, r_rd_cnt, r_wr_cnt;
  logic                  r_inflight, r_head;
  logic [1:0]            r_occ;
  logic [c_word_w-1:0]   r_buf [2];

  logic                  w_accept, w_pop, w_last_pop, w_wr_idx;
  logic [2:0]            w_credit;
  logic [c_word_w-1:0]   w_relu;

  // Lane-wise leaky ReLU applied to the word returned by the read port.
  for (genvar i = 0; i < RELU_SIZE; i++) begin : g_lane
    logic signed [COMPUTE_DATA_WIDTH-1:0] w_x;
    assign w_x = rd_data[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH];
    assign w_relu[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] =
      w_x[COMPUTE_DATA_WIDTH-1] ? (w_x >>> ALPHA) : w_x;
  end

  assign w_accept   = (r_state == ST_IDLE) && start && !abort;
  assign wr_en      = (r_occ != 2'd0);
  assign w_pop      = wr_en && wr_ready;
  assign w_last_pop = w_pop && ((r_wr_cnt + LEN_WIDTH'(1)) == r_len);
  // Credits: buffered words plus the read in flight, less the word leaving now.
  assign w_credit   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_wr_idx   = r_head ^ r_occ[0];

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign rd_en   = (r_state == ST_RUN) && (r_rd_cnt < r_len) && (w_credit < 3'd2);
  assign rd_addr = r_src + ADDR_WIDTH'(r_rd_cnt);
  assign wr_addr = r_dst + ADDR_WIDTH'(r_wr_cnt);
  assign wr_data = r_buf[r_head];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (w_last_pop) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_occ      <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_src    <= src_base;
        r_dst    <= dst_base;
        r_len    <= len;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end
      // Outside RUN, or on abort, the buffer and any returning read are dropped.
      if (r_state != ST_RUN || abort) begin
        r_occ      <= '0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= rd_en;
        r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        if (rd_en) r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
        if (w_pop) begin
          r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
          r_head   <= ~r_head;
        end
        if (r_inflight) r_buf[w_wr_idx] <= w_relu;
      end
    end
  end

`ifdef LRELU_SEQ_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (wr_en && !wr_ready && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaky_relu_seq_ctrl.sv
`default_nettype none
// tb_leaky_relu_seq_ctrl: directed, table-driven checks of the leaky ReLU job sequencer.
module tb_leaky_relu_seq_ctrl;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, wr_ready = 1'b1;
  logic [AW-1:0] src_base = '0, dst_base = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, wr_data;
`ifdef LRELU_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  leaky_relu_seq_ctrl #(
    .RELU_SIZE(4), .COMPUTE_DATA_WIDTH(4), .ALPHA(2), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef LRELU_SEQ_PERF_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] din; logic [15:0] dout; } vec_t;
  typedef struct { int cyc; logic [9:0] addr; logic [15:0] data; } ev_t;

  vec_t        vec [8];
  ev_t         rdq[$], wrq[$];
  int          doneq[$];
  logic [15:0] mem [1024];
  int          cyc = 0, c0 = 0, idle_at = 0;
  int          n_pass = 0, n_total = 0;
  int          n_rd = 0, n_wr = 0, maxout = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  always @(posedge clk) cyc++;

  // Activation SRAM: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_wr_en", {31'b0, wr_en}, 32'd1);
      chk("hold_wr_addr", {22'b0, wr_addr}, {22'b0, prev_addr});
      chk("hold_wr_data", {16'b0, wr_data}, {16'b0, prev_data});
    end
    prev_stall = wr_en && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    if (rd_en) begin rdq.push_back('{cyc, rd_addr, 16'h0}); n_rd++; end
    if (wr_en && wr_ready) begin wrq.push_back('{cyc, wr_addr, wr_data}); n_wr++; end
    if (done) doneq.push_back(cyc);
    if (n_rd - n_wr > maxout) maxout = n_rd - n_wr;
  end

  task automatic clear_logs();
    rdq.delete(); wrq.delete(); doneq.delete();
    n_rd = 0; n_wr = 0; maxout = 0;
  endtask

  task automatic load_mem(input logic [9:0] s, input int n, input int vo);
    for (int i = 0; i < n; i++) mem[10'(s + i)] = vec[(vo + i) % 8].din;
  endtask

  // Starts a job and runs until busy drops; wr_ready is low for relative cycles [slo, shi).
  task automatic run_job(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                         input int slo, input int shi);
    clear_logs();
    src_base = s; dst_base = d; len = n; start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc; idle_at = -1;
    for (int k = 0; k < 300; k++) begin
      wr_ready = !(k >= slo && k < shi);
      @(negedge clk);
      if (!busy) begin idle_at = k; break; end
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input logic [9:0] s, input logic [9:0] d,
                              input int n, input int vo);
    chk({tag, "_rd_cnt"}, rdq.size(), n);
    chk({tag, "_wr_cnt"}, wrq.size(), n);
    chk({tag, "_done_cnt"}, doneq.size(), 1);
    for (int i = 0; i < n; i++) begin
      logic [9:0]  ra, wa;
      logic [15:0] wd;
      ra = '1; wa = '1; wd = 16'hdead;
      if (i < rdq.size()) ra = rdq[i].addr;
      if (i < wrq.size()) begin wa = wrq[i].addr; wd = wrq[i].data; end
      chk($sformatf("%s_rd_addr[%0d]", tag, i), {22'b0, ra}, {22'b0, 10'(s + i)});
      chk($sformatf("%s_wr_addr[%0d]", tag, i), {22'b0, wa}, {22'b0, 10'(d + i)});
      chk($sformatf("%s_wr_data[%0d]", tag, i), {16'b0, wd}, {16'b0, vec[(vo + i) % 8].dout});
    end
  endtask

  int bp_wr[6];

  initial begin
    // lanes are nibbles, lane0 = bits[3:0]; negative lanes -1..-4 -> -1, -5..-8 -> -2
    vec[0] = '{16'h0000, 16'h0000};
    vec[1] = '{16'h7654, 16'h7654};
    vec[2] = '{16'hFFFF, 16'hFFFF};
    vec[3] = '{16'h8888, 16'hEEEE};
    vec[4] = '{16'hC3B2, 16'hF3E2};
    vec[5] = '{16'h1A9D, 16'h1EEF};
    vec[6] = '{16'hE07F, 16'hF07F};
    vec[7] = '{16'h5C8B, 16'h5FEE};
    bp_wr = '{2, 6, 7, 8, 9, 10};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rd_en", {31'b0, rd_en}, 0);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_rd_addr", {22'b0, rd_addr}, 0);
    chk("rst_wr_addr", {22'b0, wr_addr}, 0);
    chk("rst_wr_data", {16'b0, wr_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word {3,-4,-8,-1} -> {3,-1,-2,-1}
    mem[5] = 16'hF8C3;
    run_job(10'd5, 10'd9, 11'd1, 0, 0);
    chk("single_rd_cnt", rdq.size(), 1);
    chk("single_wr_cnt", wrq.size(), 1);
    if (rdq.size() > 0) begin
      chk("single_rd_addr", {22'b0, rdq[0].addr}, 5);
      chk("single_rd_cyc", rdq[0].cyc - c0, 0);
    end
    if (wrq.size() > 0) begin
      chk("single_wr_addr", {22'b0, wrq[0].addr}, 9);
      chk("single_wr_data", {16'b0, wrq[0].data}, 32'h0000FEF3);
      chk("single_wr_cyc", wrq[0].cyc - c0, 2);
    end
    chk("single_done_cnt", doneq.size(), 1);
    if (doneq.size() > 0) chk("single_done_cyc", doneq[0] - c0, 3);
    chk("single_busy_fall", idle_at, 4);

    // Streaming, full throughput
    load_mem(10'd100, 8, 0);
    run_job(10'd100, 10'd200, 11'd8, 0, 0);
    check_stream("stream", 10'd100, 10'd200, 8, 0);
    for (int i = 0; i < 8; i++) begin
      if (i < rdq.size()) chk($sformatf("stream_rd_cyc[%0d]", i), rdq[i].cyc - c0, i);
      if (i < wrq.size()) chk($sformatf("stream_wr_cyc[%0d]", i), wrq[i].cyc - c0, 2 + i);
    end
    if (doneq.size() > 0) chk("stream_done_cyc", doneq[0] - c0, 10);
    chk("stream_busy_fall", idle_at, 11);
    chk("stream_maxout", {31'b0, maxout <= 2}, 1);

    // Backpressure: wr_ready low in relative cycles 3,4,5
    load_mem(10'd300, 6, 2);
    run_job(10'd300, 10'd400, 11'd6, 3, 6);
    check_stream("bp", 10'd300, 10'd400, 6, 2);
    for (int i = 0; i < 6; i++)
      if (i < wrq.size()) chk($sformatf("bp_wr_cyc[%0d]", i), wrq[i].cyc - c0, bp_wr[i]);
    if (doneq.size() > 0) chk("bp_done_cyc", doneq[0] - c0, 11);
    chk("bp_maxout", {31'b0, maxout <= 2}, 1);
`ifdef LRELU_SEQ_PERF_EN
    chk("bp_perf_stalls", perf_stalls, 3);
    chk("bp_perf_cycles", perf_cycles, 11);
`endif

    // Address wrap
    load_mem(10'd1022, 4, 4);
    run_job(10'd1022, 10'd50, 11'd4, 0, 0);
    check_stream("wrap", 10'd1022, 10'd50, 4, 4);

    // Zero length
    run_job(10'd7, 10'd8, 11'd0, 0, 0);
    chk("zero_rd_cnt", rdq.size(), 0);
    chk("zero_wr_cnt", wrq.size(), 0);
    chk("zero_done_cnt", doneq.size(), 1);
    if (doneq.size() > 0) chk("zero_done_cyc", doneq[0] - c0, 0);
    chk("zero_busy_fall", idle_at, 1);

    // Abort 3 cycles into a len=8 job, with a start attempt while busy
    load_mem(10'd600, 8, 0);
    clear_logs();
    src_base = 10'd600; dst_base = 10'd700; len = 11'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b1; src_base = 10'd900; len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_rd_en", {31'b0, rd_en}, 0);
    chk("abort_wr_en", {31'b0, wr_en}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_rd_cnt", rdq.size(), 3);
    chk("abort_wr_cnt", wrq.size(), 1);
    chk("abort_done_cnt", doneq.size(), 0);
    chk("abort_busy_after", {31'b0, busy}, 0);
    if (rdq.size() > 2) chk("busy_start_ignored", {22'b0, rdq[2].addr}, 602);
    if (wrq.size() > 0) chk("abort_wr_addr", {22'b0, wrq[0].addr}, 700);

    // start + abort together in IDLE: no job
    clear_logs();
    src_base = 10'd0; len = 11'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", {31'b0, busy}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("startabort_rd_cnt", rdq.size(), 0);
    chk("startabort_done_cnt", doneq.size(), 0);

    // Asynchronous reset mid-job, then a fresh job
    load_mem(10'd10, 8, 3);
    clear_logs();
    src_base = 10'd10; dst_base = 10'd20; len = 11'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_rd_en", {31'b0, rd_en}, 0);
    chk("arst_wr_en", {31'b0, wr_en}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_rd_addr", {22'b0, rd_addr}, 0);
    chk("arst_wr_addr", {22'b0, wr_addr}, 0);
    chk("arst_wr_data", {16'b0, wr_data}, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_done", doneq.size(), 0);
    run_job(10'd10, 10'd20, 11'd3, 0, 0);
    check_stream("post_rst", 10'd10, 10'd20, 3, 3);
    chk("post_rst_busy_fall", idle_at, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
